// File: rtl/seg7_scan_if.sv
// seg7_scan_if: display channel between the CPU syscall side and the seven-segment scanner
//   data[31:0] value to show, load write strobe, halted syscall-exit level,
//   an[7:0] active-low anodes, seg[7:0] active-low segments {dp,g,f,e,d,c,b,a}
interface seg7_scan_if;
  logic [31:0] data;
  logic        load;
  logic        halted;
  logic [7:0]  an;
  logic [7:0]  seg;
  modport master (output data, load, halted, input an, seg);
  modport slave (input data, load, halted, output an, seg);
endinterface

// File: rtl/seg7_scan.sv
// seg7_scan: time-multiplexed eight-digit hex seven-segment driver with load shadow and halt dp
//   clk rising-edge clock, rst async active-high reset, bus slave modport of seg7_scan_if
//   SCAN_DIV dwell cycles per digit (2..2^24-1)
//   SEG7_LEADING_ZERO_BLANK_EN blanks leading-zero digits 1..7 when defined
module seg7_scan #(
  parameter int SCAN_DIV = 100000
) (
  input logic        clk,
  input logic        rst,
  seg7_scan_if.slave bus
);
  localparam logic [6:0] HEX [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };
  logic [31:0] shadow_q, shadow_d;
  logic [23:0] pre_q, pre_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  an_q, an_d, seg_q, seg_d;
  logic [3:0]  nib;
  logic        tc, blank;
  always_comb begin
    tc = pre_q == 24'(SCAN_DIV - 1);
    pre_d = tc ? '0 : pre_q + 24'd1;
    idx_d = tc ? idx_q + 3'd1 : idx_q;
    shadow_d = bus.load ? bus.data : shadow_q;
    nib = shadow_q[{idx_q, 2'b00} +: 4];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    // digit idx is a leading zero when it and every higher nibble are zero
    blank = idx_q != 3'd0 && (shadow_q >> {idx_q, 2'b00}) == 32'd0;
`else
    blank = 1'b0;
`endif
    an_d = ~(8'b1 << idx_q);
    seg_d = {~(idx_q == 3'd0 && bus.halted), blank ? 7'h7F : HEX[nib]};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_q <= '0;
      pre_q <= '0;
      idx_q <= '0;
      an_q <= 8'hFF;
      seg_q <= 8'hFF;
    end else begin
      shadow_q <= shadow_d;
      pre_q <= pre_d;
      idx_q <= idx_d;
      an_q <= an_d;
      seg_q <= seg_d;
    end
  end
  assign bus.an = an_q;
  assign bus.seg = seg_q;
endmodule

// File: tb/tb_seg7_scan.sv
// tb_seg7_scan: randomized scoreboard bench for seg7_scan with SCAN_DIV=4
module tb_seg7_scan;
  localparam int DIV = 4;
  logic clk = 1'b0;
  logic rst = 1'b0;
  seg7_scan_if bus ();
  seg7_scan #(.SCAN_DIV(DIV)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  int lut [16] = '{'h40, 'h79, 'h24, 'h30, 'h19, 'h12, 'h02, 'h78,
                   'h00, 'h10, 'h08, 'h03, 'h46, 'h21, 'h06, 'h0E};
  logic [15:0] sb [$];
  logic [31:0] model_sh;
  int k;
  int pass_cnt = 0;
  int tot_cnt = 0;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got an=%h seg=%h, want an=%h seg=%h", nm, act[15:8], act[7:0], exp[15:8], exp[7:0]);
  endtask

  // expected {an,seg} right after the k-th edge since reset release
  function automatic logic [15:0] expect_out(input int kk, input logic [31:0] sh, input logic h);
    int d;
    int s;
    logic [31:0] upper;
    d = ((kk - 1) / DIV) % 8;
    upper = sh >> (4 * d);
    s = lut[upper & 32'hF];
`ifdef SEG7_LEADING_ZERO_BLANK_EN
    if (d != 0 && upper == 0) s = 'h7F;
`endif
    if (!(d == 0 && h)) s = s + 'h80;
    return {8'hFF ^ 8'(1 << d), 8'(s)};
  endfunction

  task automatic step(input logic ld, input logic [31:0] d, input logic h);
    bus.load = ld;
    bus.data = d;
    bus.halted = h;
    k++;
    sb.push_back(expect_out(k, model_sh, h));
    if (ld) model_sh = d;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input logic h);
    for (int i = 0; i < n; i++) step(1'b0, $urandom, h);
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    bus.load = 1'b0;
    #1 chk("async_reset", {bus.an, bus.seg}, 16'hFFFF);
    @(negedge clk);
    chk("held_reset", {bus.an, bus.seg}, 16'hFFFF);
    rst = 1'b0;
    model_sh = '0;
    k = 0;
  endtask

  initial begin : monitor
    logic [15:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("scan", {bus.an, bus.seg}, e);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: run did not complete");
    $fatal(1);
  end

  initial begin
    bus.load = 1'b0;
    bus.data = '0;
    bus.halted = 1'b0;
    model_sh = '0;
    k = 0;
    @(negedge clk);
    do_reset();
    idle(32, 1'b0);
    do_reset();
    step(1'b1, 32'h1234ABCD, 1'b0);
    idle(64, 1'b0);
    do_reset();
    idle(5, 1'b0);
    while ((k + 1) % DIV != 0) step(1'b0, '0, 1'b0);
    step(1'b1, 32'hFFFFFFFF, 1'b0);
    idle(8, 1'b0);
    do_reset();
    idle(32, 1'b1);
    idle(32, 1'b0);
    do_reset();
    step(1'b1, 32'h000000A5, 1'b0);
    idle(32, 1'b0);
    do_reset();
    step(1'b1, 32'h0000_3000, 1'b0);
    idle(32, 1'b0);
    do_reset();
    step(1'b1, 32'h8765_4321, 1'b0);
    idle(21, 1'b0);
    do_reset();
    idle(40, 1'b0);
    for (int i = 0; i < 500; i++) begin
      logic [31:0] d;
      d = $urandom;
      if ($urandom_range(0, 2) == 0) d = d >> (4 * $urandom_range(0, 7));
      step($urandom_range(0, 5) == 0, d, $urandom_range(0, 3) == 0);
    end
    @(negedge clk);
    tot_cnt++;
    if (sb.size() == 0) pass_cnt++;
    else $display("FAIL drain: %0d expected outputs left, want 0", sb.size());
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end
endmodule
